// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants, fetch FSM encoding and PC helpers for inst_fetch
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INST_W           = 32;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small FIFO of {instruction, pc} pairs with flush and occupancy count
module fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [INST_W-1:0]          push_code,
    input  logic [31:0]                push_pc,
    input  logic                       pop,
    input  logic                       flush,
    output logic [INST_W-1:0]          head_code,
    output logic [31:0]                head_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];

    logic [INST_W-1:0] code_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != '0);
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push && ((count != FULL) || do_pop);

    assign head_code = code_mem[rd_ptr];
    assign head_pc   = pc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) begin
            code_mem[wr_ptr] <= push_code;
            pc_mem[wr_ptr]   <= push_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch: PC, single-outstanding memory request FSM and fetch queue
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Redirect,
    input  logic [31:0]       RedirectPC,
    output logic              ImemReq,
    output logic [31:0]       ImemAddr,
    input  logic              ImemGnt,
    input  logic              ImemRValid,
    input  logic [INST_W-1:0] ImemRData,
    output logic              InstValid,
    output logic [INST_W-1:0] InstCode,
    output logic [31:0]       InstPC,
    input  logic              InstReady
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] QLIM = QDEPTH[CW:0];

    fetch_state_e      state;
    fetch_state_e      state_nxt;
    logic [31:0]       pc;
    logic [31:0]       issue_pc;
    logic [CW-1:0]     occ;
    logic [CW:0]       need;
    logic [INST_W-1:0] head_code;
    logic [31:0]       head_pc;
    logic              in_wait;
    logic              pop;
    logic              fire;
    logic              push;

    assign in_wait = (state == ST_WAIT);
    assign pop     = InstValid && InstReady;

    // Slots committed after this edge: the in-flight word lands in the queue, a pop frees one.
    assign need = {1'b0, occ} + {{CW{1'b0}}, in_wait} - {{CW{1'b0}}, pop};

    assign ImemReq  = !reset && !Redirect && (state != ST_DROP)
                    && ((state == ST_RUN) || ImemRValid) && (need < QLIM);
    assign ImemAddr = pc;
    assign fire     = ImemReq && ImemGnt;
    assign push     = ImemRValid && in_wait && !Redirect;

    assign InstValid = !reset && (occ != '0);
    assign InstCode  = InstValid ? head_code : '0;
    assign InstPC    = InstValid ? head_pc : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            issue_pc <= '0;
        end else begin
            state <= state_nxt;
            if (Redirect)  pc <= align_pc(RedirectPC);
            else if (fire) pc <= pc + PC_INC;
            if (fire) issue_pc <= pc;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (fire) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A response landing in the redirect cycle is dropped right here; otherwise wait it out.
                if (Redirect)        state_nxt = ImemRValid ? ST_RUN : ST_DROP;
                else if (ImemRValid) state_nxt = fire ? ST_WAIT : ST_RUN;
            end
            ST_DROP: begin
                if (ImemRValid) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_code (ImemRData),
        .push_pc   (issue_pc),
        .pop       (pop),
        .flush     (Redirect),
        .head_code (head_code),
        .head_pc   (head_pc),
        .count     (occ)
    );

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter QDEPTH, default 2: fetch-queue entries; legal values 2 or 4.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Redirect  input  1  taken branch/jump from execute; overrides all other activity.
REQ-006 RedirectPC  input  32  redirect target; bits [1:0] forced to 00 internally.
REQ-007 ImemReq  output  1  instruction-memory read request.
REQ-008 ImemAddr  output  32  word-aligned read address, valid while ImemReq=1.
REQ-009 ImemGnt  input  1  request accepted this cycle.
REQ-010 ImemRValid  input  1  read data valid; arrives exactly one cycle after the granting cycle.
REQ-011 ImemRData  input  32  instruction word.
REQ-012 InstValid  output  1  queue head holds a valid instruction.
REQ-013 InstCode  output  32  instruction word to decode/immediate generation.
REQ-014 InstPC  output  32  address of InstCode.
REQ-015 InstReady  input  1  decode accepts head; transfer when InstValid&InstReady.

Function
REQ-016 PC register SHALL drive ImemAddr; PC advances by 4 (mod 2^32, wrap silently) on each ImemReq&ImemGnt.
REQ-017 ImemReq SHALL assert only when occupancy + in-flight < QDEPTH and Redirect=0; hence the queue never overflows.
REQ-018 At most one request SHALL be in flight.
REQ-019 FSM states: RUN (none in flight), WAIT (one in flight), DROP (in-flight response to discard).
REQ-020 RUN->WAIT on grant; WAIT->RUN on ImemRValid with no new grant; WAIT->WAIT on ImemRValid with a new grant the same cycle.
REQ-021 Redirect in WAIT, or in RUN coincident with a grant, SHALL go to DROP; DROP->RUN on ImemRValid with the response discarded.
REQ-022 In DROP, ImemReq SHALL be 0.
REQ-023 On a non-discarded ImemRValid, {ImemRData, issuing PC} SHALL be pushed at the queue tail.
REQ-024 Queue is FIFO. Output is the head, combinational from storage. InstValid = occupancy!=0.
REQ-025 Push and pop in the same cycle SHALL leave occupancy unchanged; pop on empty SHALL be ignored.
REQ-026 Redirect SHALL, next cycle: set PC=RedirectPC with [1:0]=00, flush occupancy to 0, deassert InstValid.
REQ-027 A pop coincident with Redirect is discarded by the flush.
REQ-028 Fetch latency: grant in cycle N -> InstValid=1 in cycle N+2, absent stall or redirect.
REQ-029 Sustained throughput SHALL be one instruction per cycle when ImemGnt and InstReady are held high.
REQ-030 ImemRValid arriving with nothing in flight SHALL be ignored.

Reset
REQ-031 While reset=1: PC=RESET_PC, FSM=RUN, occupancy=0, in-flight cleared, ImemReq=0, InstValid=0, InstCode=0, InstPC=0.
REQ-032 Reset mid-fetch SHALL discard any in-flight response; a stale ImemRValid in the first cycle after reset SHALL be ignored.
REQ-033 ImemReq SHALL first assert in the first cycle after reset deasserts, with ImemAddr=RESET_PC.

Structure
REQ-034 Shared package holds RESET_PC default, instruction width (32), PC increment (4), and FSM state encoding.
REQ-035 Queue SHALL be a sub-module fetch_queue: parameterized depth, data+PC payload, push/pop/flush, occupancy output.

Verification
REQ-036 Reset release, ImemGnt=1, InstReady=1, memory returns 32'h0000_0013 per word -> InstPC 0,4,8,... one per cycle; first InstValid two cycles after first grant.
REQ-037 InstReady=0 for 6 cycles -> occupancy stops at QDEPTH; ImemReq drops; no instruction lost or duplicated after InstReady returns.
REQ-038 Redirect to 32'h0000_0102 while a request is in flight -> in-flight response discarded, queue flushed, next ImemAddr=32'h0000_0100.
REQ-039 PC=32'hFFFF_FFFC granted -> next ImemAddr=32'h0000_0000.
REQ-040 Reset asserted in WAIT, with ImemRValid the following cycle -> no push; InstValid=0; first post-reset address = RESET_PC.
REQ-041 Push and pop in the same cycle with the queue full -> occupancy holds at QDEPTH; order preserved.
